// File: rtl/y86_mem_stage_p.sv
// y86_mem_stage_p
// Y86-64 memory stage: byte-addressable little-endian data memory with a
// configurable access latency, address-error detection, status priority,
// store suppression behind exceptions, and the M->W pipeline register.
//
// Parameters:
//   DEPTH   - data memory size in bytes (multiple of 8, >= 16)
//   MEM_LAT - cycles a memory access occupies the stage (>= 1)
//
// Optional feature macro:
//   MEM_ALIGN_CHK_EN - when defined, accesses with addr[2:0] != 0 raise ADR.
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   M_stat/M_icode/M_valE/M_valA/
//   M_valP/M_dstE/M_dstM            execute->memory pipeline register fields
//   W_stall, W_bubble               hazard-unit control of the W register
//   m_valM, m_stat                  combinational read data / stage status
//   m_busy                          combinational stall request
//   W_stat/W_icode/W_valE/W_valM/
//   W_dstE/W_dstM                   registered write-back fields
module y86_mem_stage_p #(
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  M_stat,
    input  logic [3:0]  M_icode,
    input  logic [63:0] M_valE,
    input  logic [63:0] M_valA,
    input  logic [63:0] M_valP,
    input  logic [3:0]  M_dstE,
    input  logic [3:0]  M_dstM,
    input  logic        W_stall,
    input  logic        W_bubble,
    output logic [63:0] m_valM,
    output logic [2:0]  m_stat,
    output logic        m_busy,
    output logic [2:0]  W_stat,
    output logic [3:0]  W_icode,
    output logic [63:0] W_valE,
    output logic [63:0] W_valM,
    output logic [3:0]  W_dstE,
    output logic [3:0]  W_dstM
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam bit          MULTI = (MEM_LAT > 1);

    localparam logic [63:0]      ADDR_MAX = 64'(DEPTH - 8);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    localparam logic [3:0] ICODE_NOP = 4'h1;
    localparam logic [3:0] REG_NONE  = 4'hF;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;

    logic        is_wr, is_rd, access;
    logic [63:0] addr, wdata;
    logic        range_err, align_err, adr_err;
    logic        w_exc, acc_ok, done;
    logic        do_write, rd_ok;
    logic [63:0] rd_word;
    logic [AW-1:0] wa;

    logic [7:0] mem [DEPTH];

    // Access decode: direction, address source and store data
    always_comb begin
        is_wr = 1'b0;
        is_rd = 1'b0;
        addr  = M_valE;
        wdata = M_valA;
        case (M_icode)
            4'h4: is_wr = 1'b1;
            4'h8: begin
                is_wr = 1'b1;
                wdata = M_valP;
            end
            4'hA: is_wr = 1'b1;
            4'h5: is_rd = 1'b1;
            4'h9, 4'hB: begin
                is_rd = 1'b1;
                addr  = M_valA;
            end
            default: ;
        endcase
    end

    assign access    = is_wr | is_rd;
    // Full 64-bit unsigned compare so huge addresses cannot wrap into range
    assign range_err = (addr > ADDR_MAX);

`ifdef MEM_ALIGN_CHK_EN
    assign align_err = (addr[2:0] != 3'd0);
`else
    assign align_err = 1'b0;
`endif

    assign adr_err = access & (range_err | align_err);
    assign m_stat  = adr_err ? STAT_ADR : M_stat;

    // An earlier instruction already in W raised an exception
    assign w_exc  = (W_stat == STAT_HLT) | (W_stat == STAT_ADR) | (W_stat == STAT_INS);
    assign acc_ok = access & (M_stat == STAT_AOK) & ~adr_err & ~w_exc;

    // Next-state and stall request
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        m_busy   = 1'b0;
        done     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (acc_ok) begin
                    if (MULTI) begin
                        m_busy   = 1'b1;
                        state_nx = ST_WAIT;
                        cnt_nx   = CNT_LOAD;
                    end else begin
                        done = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt > CNT_W'(1)) begin
                    m_busy = 1'b1;
                    cnt_nx = cnt - CNT_W'(1);
                end else begin
                    done     = 1'b1;
                    state_nx = ST_IDLE;
                    cnt_nx   = '0;
                end
            end
            default: begin
                state_nx = ST_IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    // State register; frozen while W is stalled
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else if (!W_stall) begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    assign do_write = done & acc_ok & is_wr & ~W_stall;
    assign rd_ok    = done & acc_ok & is_rd;
    assign wa       = addr[AW-1:0];

    // Little-endian 8-byte read
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < 8; i++) begin
            rd_word[8*i +: 8] = mem[AW'(wa + AW'(i))];
        end
    end

    assign m_valM = rd_ok ? rd_word : 64'd0;

    // Data memory write port; contents survive reset, but a reset edge blocks the commit
    always_ff @(posedge clk) begin
        if (rst_n && do_write) begin
            for (int i = 0; i < 8; i++) begin
                mem[AW'(wa + AW'(i))] <= wdata[8*i +: 8];
            end
        end
    end

    // M->W pipeline register: stall holds, busy or bubble inserts a nop
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            W_stat  <= STAT_AOK;
            W_icode <= ICODE_NOP;
            W_valE  <= '0;
            W_valM  <= '0;
            W_dstE  <= REG_NONE;
            W_dstM  <= REG_NONE;
        end else if (!W_stall) begin
            if (W_bubble || m_busy) begin
                W_stat  <= STAT_AOK;
                W_icode <= ICODE_NOP;
                W_valE  <= '0;
                W_valM  <= '0;
                W_dstE  <= REG_NONE;
                W_dstM  <= REG_NONE;
            end else begin
                W_stat  <= m_stat;
                W_icode <= M_icode;
                W_valE  <= M_valE;
                W_valM  <= m_valM;
                W_dstE  <= M_dstE;
                W_dstM  <= M_dstM;
            end
        end
    end

endmodule

// File: tb/tb_y86_mem_stage_p.sv
// Bench for y86_mem_stage_p: three instances with MEM_LAT 1, 3 and 4.
// Stimulus pushes expected W contents into per-instance queues; a monitor
// pops and compares each time a non-nop instruction is loaded into W.
module tb_y86_mem_stage_p;

    localparam int unsigned NDUT  = 3;
    localparam int unsigned DEPTH = 1024;

    typedef struct packed {
        logic [2:0]  stat;
        logic [3:0]  icode;
        logic [63:0] valE;
        logic [63:0] valA;
        logic [63:0] valP;
        logic [3:0]  dstE;
        logic [3:0]  dstM;
    } m_in_t;

    typedef struct packed {
        logic [2:0]  stat;
        logic [3:0]  icode;
        logic [63:0] valE;
        logic [63:0] valM;
        logic [3:0]  dstE;
        logic [3:0]  dstM;
    } w_exp_t;

    logic clk = 1'b0;
    logic rst_n    [NDUT];
    logic W_stall  [NDUT];
    logic W_bubble [NDUT];
    m_in_t m_in    [NDUT];

    logic [63:0] m_valM  [NDUT];
    logic [2:0]  m_stat  [NDUT];
    logic        m_busy  [NDUT];
    logic [2:0]  W_stat  [NDUT];
    logic [3:0]  W_icode [NDUT];
    logic [63:0] W_valE  [NDUT];
    logic [63:0] W_valM  [NDUT];
    logic [3:0]  W_dstE  [NDUT];
    logic [3:0]  W_dstM  [NDUT];
    logic        loaded  [NDUT];

    int n_vec = 0;
    int n_err = 0;

    w_exp_t sb0[$];
    w_exp_t sb1[$];
    w_exp_t sb2[$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int unsigned LAT = (g == 0) ? 1 : ((g == 1) ? 3 : 4);
        y86_mem_stage_p #(.DEPTH(DEPTH), .MEM_LAT(LAT)) u_dut (
            .clk      (clk),
            .rst_n    (rst_n[g]),
            .M_stat   (m_in[g].stat),
            .M_icode  (m_in[g].icode),
            .M_valE   (m_in[g].valE),
            .M_valA   (m_in[g].valA),
            .M_valP   (m_in[g].valP),
            .M_dstE   (m_in[g].dstE),
            .M_dstM   (m_in[g].dstM),
            .W_stall  (W_stall[g]),
            .W_bubble (W_bubble[g]),
            .m_valM   (m_valM[g]),
            .m_stat   (m_stat[g]),
            .m_busy   (m_busy[g]),
            .W_stat   (W_stat[g]),
            .W_icode  (W_icode[g]),
            .W_valE   (W_valE[g]),
            .W_valM   (W_valM[g]),
            .W_dstE   (W_dstE[g]),
            .W_dstM   (W_dstM[g])
        );
    end

    function automatic m_in_t mk(input logic [2:0] s, input logic [3:0] ic,
                                 input logic [63:0] e, input logic [63:0] a,
                                 input logic [63:0] p, input logic [3:0] de,
                                 input logic [3:0] dm);
        return {s, ic, e, a, p, de, dm};
    endfunction

    function automatic void sb_push(input int g, input w_exp_t e);
        case (g)
            0:       sb0.push_back(e);
            1:       sb1.push_back(e);
            default: sb2.push_back(e);
        endcase
    endfunction

    function automatic int sb_size(input int g);
        case (g)
            0:       return sb0.size();
            1:       return sb1.size();
            default: return sb2.size();
        endcase
    endfunction

    function automatic w_exp_t sb_pop(input int g);
        case (g)
            0:       return sb0.pop_front();
            1:       return sb1.pop_front();
            default: return sb2.pop_front();
        endcase
    endfunction

    task automatic chk(input string nm, input int g, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d: got %0h required %0h", nm, g, act, exp);
        end
    endtask

    // Was W written at the last rising edge
    always @(posedge clk) begin
        for (int g = 0; g < NDUT; g++) loaded[g] <= rst_n[g] && !W_stall[g];
    end

    // Scoreboard monitor
    always @(negedge clk) begin
        for (int g = 0; g < NDUT; g++) begin
            if (loaded[g] === 1'b1 && W_icode[g] != 4'h1) begin
                w_exp_t act;
                w_exp_t e;
                act = {W_stat[g], W_icode[g], W_valE[g], W_valM[g], W_dstE[g], W_dstM[g]};
                n_vec++;
                if (sb_size(g) == 0) begin
                    n_err++;
                    $display("FAIL w_unexpected dut%0d: got %h required none", g, act);
                end else begin
                    e = sb_pop(g);
                    if (act !== e) begin
                        n_err++;
                        $display("FAIL w_reg dut%0d: got %h required %h", g, act, e);
                    end
                end
            end
        end
    end

    // Present one instruction, hold it while busy, check stage outputs at completion
    task automatic issue(input int g, input m_in_t x, input logic [63:0] exp_valM,
                         input logic [2:0] exp_mstat, input int exp_busy, input bit gap);
        int  nb;
        bit  done;
        logic b;
        nb   = 0;
        done = 1'b0;
        m_in[g] = x;
        sb_push(g, {exp_mstat, x.icode, x.valE, exp_valM, x.dstE, x.dstM});
        for (int c = 0; c < 32; c++) begin
            @(negedge clk);
            if (c > 0) chk("bubble_in_w", g, 64'(W_icode[g]), 64'h1);
            b = m_busy[g];
            if (!b) begin
                chk("m_valM", g, m_valM[g], exp_valM);
                chk("m_stat", g, 64'(m_stat[g]), 64'(exp_mstat));
                done = 1'b1;
            end else begin
                nb++;
            end
            @(posedge clk);
            #1;
            if (!b) break;
        end
        chk("complete", g, 64'(done), 64'h1);
        chk("busy_cycles", g, 64'(nb), 64'(exp_busy));
        if (gap) begin
            m_in[g] = mk(3'd1, 4'h1, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1);
    end

    initial begin
        m_in_t nop;
        nop = mk(3'd1, 4'h1, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF);
        for (int g = 0; g < NDUT; g++) begin
            rst_n[g]    = 1'b0;
            W_stall[g]  = 1'b0;
            W_bubble[g] = 1'b0;
            m_in[g]     = nop;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < NDUT; g++) rst_n[g] = 1'b1;

        // Reset state of every instance
        @(negedge clk);
        for (int g = 0; g < NDUT; g++) begin
            chk("rst_W_stat",  g, 64'(W_stat[g]),  64'h1);
            chk("rst_W_icode", g, 64'(W_icode[g]), 64'h1);
            chk("rst_W_dstE",  g, 64'(W_dstE[g]),  64'hF);
            chk("rst_W_dstM",  g, 64'(W_dstM[g]),  64'hF);
            chk("rst_W_valE",  g, W_valE[g],       64'h0);
            chk("rst_W_valM",  g, W_valM[g],       64'h0);
        end
        @(posedge clk);
        #1;

        // ---- MEM_LAT = 1 ----
        issue(0, mk(3'd1, 4'h4, 64'h100, 64'h1122334455667788, 64'd0, 4'hF, 4'hF), 64'd0, 3'd1, 0, 1'b0);
        issue(0, mk(3'd1, 4'h5, 64'h100, 64'd0, 64'd0, 4'hF, 4'h3), 64'h1122334455667788, 3'd1, 0, 1'b1);
        chk("byte_0x100", 0, 64'(g_dut[0].u_dut.mem[256]), 64'h88);
        issue(0, mk(3'd1, 4'h4, 64'h108, 64'h0102030405060708, 64'd0, 4'hF, 4'hF), 64'd0, 3'd1, 0, 1'b1);
`ifdef MEM_ALIGN_CHK_EN
        issue(0, mk(3'd1, 4'h5, 64'h104, 64'd0, 64'd0, 4'hF, 4'h1), 64'd0, 3'd3, 0, 1'b1);
`else
        issue(0, mk(3'd1, 4'h5, 64'h104, 64'd0, 64'd0, 4'hF, 4'h1), 64'h0506070811223344, 3'd1, 0, 1'b1);
`endif
        // call stores valP, ret reads through valA
        issue(0, mk(3'd1, 4'h8, 64'h180, 64'd0, 64'hABC, 4'h4, 4'hF), 64'd0, 3'd1, 0, 1'b1);
        issue(0, mk(3'd1, 4'h9, 64'h188, 64'h180, 64'd0, 4'h4, 4'hF), 64'hABC, 3'd1, 0, 1'b1);
        // Boundary: DEPTH-8 legal, DEPTH-4 / DEPTH-7 / near 2^64 illegal
        issue(0, mk(3'd1, 4'h4, 64'd1016, 64'hA5A5000012345678, 64'd0, 4'hF, 4'hF), 64'd0, 3'd1, 0, 1'b1);
        issue(0, mk(3'd1, 4'hA, 64'd1020, 64'hDEAD, 64'd0, 4'h4, 4'hF), 64'd0, 3'd3, 0, 1'b1);
        issue(0, mk(3'd1, 4'h5, 64'd1016, 64'd0, 64'd0, 4'hF, 4'h2), 64'hA5A5000012345678, 3'd1, 0, 1'b1);
        issue(0, mk(3'd1, 4'h5, 64'd1017, 64'd0, 64'd0, 4'hF, 4'h2), 64'd0, 3'd3, 0, 1'b1);
        issue(0, mk(3'd1, 4'hB, 64'h40, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0, 4'h4, 4'h5), 64'd0, 3'd3, 0, 1'b1);

        // Store suppression: halt in W, rmmovq in M under stall
        issue(0, mk(3'd2, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF), 64'd0, 3'd2, 0, 1'b0);
        m_in[0]    = mk(3'd1, 4'h4, 64'h100, 64'hBAD, 64'd0, 4'hF, 4'hF);
        W_stall[0] = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("stall_W_icode", 0, 64'(W_icode[0]), 64'h0);
            chk("stall_W_stat",  0, 64'(W_stat[0]),  64'h2);
            chk("stall_busy",    0, 64'(m_busy[0]),  64'h0);
            @(posedge clk);
            #1;
        end
        chk("suppr_byte_0x100", 0, 64'(g_dut[0].u_dut.mem[256]), 64'h88);
        sb_push(0, {3'd1, 4'h4, 64'h100, 64'd0, 4'hF, 4'hF});
        W_stall[0] = 1'b0;
        @(posedge clk);
        #1;
        m_in[0] = nop;
        @(posedge clk);
        #1;
        // Store with non-AOK incoming status is dropped
        issue(0, mk(3'd4, 4'h4, 64'h100, 64'hBAD, 64'd0, 4'hF, 4'hF), 64'd0, 3'd4, 0, 1'b1);
        // Bubble request replaces the load in W
        m_in[0]     = mk(3'd1, 4'h5, 64'h100, 64'd0, 64'd0, 4'hF, 4'h3);
        W_bubble[0] = 1'b1;
        @(negedge clk);
        chk("bub_m_valM", 0, m_valM[0], 64'h1122334455667788);
        @(posedge clk);
        #1;
        W_bubble[0] = 1'b0;
        m_in[0]     = nop;
        @(negedge clk);
        chk("bub_W_icode", 0, 64'(W_icode[0]), 64'h1);
        chk("bub_W_dstM",  0, 64'(W_dstM[0]),  64'hF);
        @(posedge clk);
        #1;
        issue(0, mk(3'd1, 4'h5, 64'h100, 64'd0, 64'd0, 4'hF, 4'h3), 64'h1122334455667788, 3'd1, 0, 1'b1);

        // ---- MEM_LAT = 3 ----
        issue(1, mk(3'd1, 4'h4, 64'h40, 64'h0F0E0D0C0B0A0908, 64'd0, 4'hF, 4'hF), 64'd0, 3'd1, 2, 1'b0);
        issue(1, mk(3'd1, 4'h5, 64'h40, 64'd0, 64'd0, 4'hF, 4'h2), 64'h0F0E0D0C0B0A0908, 3'd1, 2, 1'b1);
        issue(1, mk(3'd1, 4'hA, 64'd1020, 64'h77, 64'd0, 4'h4, 4'hF), 64'd0, 3'd3, 0, 1'b1);

        // ---- MEM_LAT = 4: reset in the completion cycle of a store ----
        issue(2, mk(3'd1, 4'h4, 64'h200, 64'h5555666677778888, 64'd0, 4'hF, 4'hF), 64'd0, 3'd1, 3, 1'b1);
        m_in[2] = mk(3'd1, 4'h4, 64'h200, 64'h9999, 64'd0, 4'hF, 4'hF);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rst_pre_busy", 2, 64'(m_busy[2]), 64'h1);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        rst_n[2] = 1'b0;
        @(posedge clk);
        #1;
        rst_n[2] = 1'b1;
        m_in[2]  = nop;
        @(negedge clk);
        chk("midrst_W_icode", 2, 64'(W_icode[2]), 64'h1);
        chk("midrst_W_stat",  2, 64'(W_stat[2]),  64'h1);
        chk("midrst_busy",    2, 64'(m_busy[2]),  64'h0);
        @(posedge clk);
        #1;
        issue(2, mk(3'd1, 4'h5, 64'h200, 64'd0, 64'd0, 4'hF, 4'h1), 64'h5555666677778888, 3'd1, 3, 1'b1);

        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < NDUT; g++) chk("sb_drained", g, 64'(sb_size(g)), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
